// File: rtl/dotmat_pkg.sv
// rtl/dotmat_pkg.sv - shared defaults, scan state type and row-select helper for the dot matrix driver
package dotmat_pkg;

  localparam int DEF_ROWS      = 16;
  localparam int DEF_COLS      = 16;
  localparam int DEF_SCAN_DIV  = 9375;
  localparam int DEF_BLANK_CYC = 4;
  localparam int DEF_PWM_BITS  = 4;

  // Widest row-select vector the helper can build; callers cast down to ROWS bits.
  localparam int MAX_ROWS = 64;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_ON    = 1'b1
  } scan_state_t;

  // Active-low one-hot row select with row 0 on the MSB of a rows-wide field.
  function automatic logic [MAX_ROWS-1:0] row_onehot_n(input int idx, input int rows);
    logic [MAX_ROWS-1:0] one;
    one = {{(MAX_ROWS-1){1'b0}}, 1'b1};
    return ~(one << (rows - 1 - idx));
  endfunction

endpackage

// File: rtl/dotmat_frame_buf.sv
// rtl/dotmat_frame_buf.sv - two-bank ROWS x COLS frame store with one write port and one read port
module dotmat_frame_buf
  import dotmat_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic                    wr_bank,
  input  logic [$clog2(ROWS)-1:0] wr_row,
  input  logic [COLS-1:0]         wr_data,
  input  logic                    rd_bank,
  input  logic [$clog2(ROWS)-1:0] rd_row,
  output logic [COLS-1:0]         rd_data
);

  localparam int RW = $clog2(ROWS);
  localparam logic [RW:0] ROWS_W = (RW + 1)'(ROWS);

  logic [COLS-1:0] mem [2][ROWS];

  // Both banks clear on reset; writes aimed past the last row are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          mem[b][r] <= '0;
        end
      end
    end else if (wr_en && ({1'b0, wr_row} < ROWS_W)) begin
      mem[wr_bank][wr_row] <= wr_data;
    end
  end

  assign rd_data = mem[rd_bank][rd_row];

endmodule

// File: rtl/dot_matrix_scan_ctrl.sv
// rtl/dot_matrix_scan_ctrl.sv - row-scan LED matrix driver with double-buffered frames; DOTMAT_PWM_EN adds brightness PWM
module dot_matrix_scan_ctrl
  import dotmat_pkg::*;
#(
  parameter int ROWS      = DEF_ROWS,
  parameter int COLS      = DEF_COLS,
  parameter int SCAN_DIV  = DEF_SCAN_DIV,
  parameter int BLANK_CYC = DEF_BLANK_CYC,
  parameter int PWM_BITS  = DEF_PWM_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [$clog2(ROWS)-1:0] wr_row,
  input  logic [COLS-1:0]         wr_data,
  input  logic                    swap_req,
  output logic                    swap_done,
  input  logic                    blink_en,
  input  logic                    blink_tick,
`ifdef DOTMAT_PWM_EN
  input  logic [PWM_BITS-1:0]     brightness,
`endif
  output logic                    frame_start,
  output logic [ROWS-1:0]         H,
  output logic [COLS-1:0]         L
);

  localparam int RW = $clog2(ROWS);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] BLANK_W   = SW'(BLANK_CYC);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);

  if (ROWS < 2 || ROWS > MAX_ROWS || COLS < 1 || BLANK_CYC < 1 ||
      SCAN_DIV <= BLANK_CYC || PWM_BITS < 1) begin : g_param_check
    $error("dot_matrix_scan_ctrl: illegal parameter set");
  end

  scan_state_t     state;
  logic [SW-1:0]   slot_cnt;
  logic [SW-1:0]   slot_cnt_next;
  logic [RW-1:0]   row;
  logic [RW-1:0]   row_next;
  logic            slot_wrap;
  logic            frame_wrap;
  logic            front;
  logic            swap_pending;
  logic            pending_next;
  logic            take_swap;
  logic            blink_phase;
  logic            blink_dark;
  logic            col_gate;
  logic            wr_fire;
  logic [COLS-1:0] front_row_data;

  // Slot timer and row sequencing for the next edge.
  always_comb begin
    slot_wrap     = (slot_cnt == SLOT_LAST);
    slot_cnt_next = slot_wrap ? '0 : slot_cnt + SW'(1);
    row_next      = row;
    if (slot_wrap) begin
      row_next = (row == ROW_LAST) ? '0 : row + RW'(1);
    end
    frame_wrap = slot_wrap && (row == ROW_LAST);
  end

  // A pending swap is consumed at the last-row wrap; requests while pending are dropped,
  // and a request landing on the boundary itself waits for the following frame.
  always_comb begin
    take_swap    = swap_pending && frame_wrap;
    pending_next = take_swap ? 1'b0 : (swap_pending || swap_req);
  end

  assign wr_fire    = wr_valid && wr_ready;
  assign blink_dark = blink_en && blink_phase;

  dotmat_frame_buf #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_frame_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_fire),
    .wr_bank (~front),
    .wr_row  (wr_row),
    .wr_data (wr_data),
    .rd_bank (front),
    .rd_row  (row),
    .rd_data (front_row_data)
  );

`ifdef DOTMAT_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt;

  // PWM phase advances once per frame so every row of a frame shares the same duty step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else if (frame_wrap) begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  assign col_gate = (pwm_cnt < brightness);
`else
  assign col_gate = 1'b1;
`endif

  // Scan FSM: blank the columns at the head of each slot, then drive the front-bank row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_BLANK;
      slot_cnt    <= '0;
      row         <= '0;
      H           <= '1;
      L           <= '1;
      frame_start <= 1'b0;
    end else begin
      slot_cnt    <= slot_cnt_next;
      row         <= row_next;
      H           <= ROWS'(row_onehot_n(int'(row_next), ROWS));
      frame_start <= frame_wrap;
      case (state)
        S_BLANK: begin
          L <= '1;
          if (slot_cnt_next >= BLANK_W) begin
            state <= S_ON;
          end
        end
        S_ON: begin
          if (slot_wrap) begin
            // Columns go dark on the same edge the row select moves, so no ghosting.
            state <= S_BLANK;
            L     <= '1;
          end else if (blink_dark) begin
            L <= '1;
          end else begin
            L <= ~(front_row_data & {COLS{col_gate}});
          end
        end
        default: begin
          state <= S_BLANK;
          L     <= '1;
        end
      endcase
    end
  end

  // Bank swap handshake and blink phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front        <= 1'b0;
      swap_pending <= 1'b0;
      wr_ready     <= 1'b1;
      swap_done    <= 1'b0;
      blink_phase  <= 1'b0;
    end else begin
      swap_pending <= pending_next;
      wr_ready     <= !pending_next && !take_swap;
      swap_done    <= take_swap;
      if (take_swap) begin
        front <= ~front;
      end
      blink_phase <= blink_en ? (blink_phase ^ blink_tick) : 1'b0;
    end
  end

endmodule

// File: tb/tb_dot_matrix_scan_ctrl.sv
// tb/tb_dot_matrix_scan_ctrl.sv - randomized self-checking bench for dot_matrix_scan_ctrl against a frame-level model
module tb_dot_matrix_scan_ctrl;

  localparam int ROWS      = 16;
  localparam int COLS      = 16;
  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = ROWS * SCAN_DIV;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_row;
  logic [15:0] wr_data;
  logic        swap_req;
  logic        swap_done;
  logic        blink_en;
  logic        blink_tick;
  logic        frame_start;
  logic [15:0] H;
  logic [15:0] L;
`ifdef DOTMAT_PWM_EN
  logic [3:0]  brightness;
`endif

  dot_matrix_scan_ctrl #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC),
    .PWM_BITS  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_row      (wr_row),
    .wr_data     (wr_data),
    .swap_req    (swap_req),
    .swap_done   (swap_done),
    .blink_en    (blink_en),
    .blink_tick  (blink_tick),
`ifdef DOTMAT_PWM_EN
    .brightness  (brightness),
`endif
    .frame_start (frame_start),
    .H           (H),
    .L           (L)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed;
  int total;
  int k;
  int swap_at;
  int req_k;
  bit chk_l;
  bit dark;
  logic [15:0] front_m [ROWS];
  logic [15:0] back_m  [ROWS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    k       = 0;
    swap_at = -1;
    req_k   = -1;
    dark    = 0;
    chk_l   = 1;
    for (int i = 0; i < ROWS; i++) begin
      front_m[i] = '0;
      back_m[i]  = '0;
    end
  endtask

  task automatic check_cycle();
    int p;
    int r;
    logic [15:0] tmp;
    logic [15:0] eh;
    logic [15:0] el;
    p = k % SCAN_DIV;
    r = (k / SCAN_DIV) % ROWS;
    if (k == swap_at) begin
      for (int i = 0; i < ROWS; i++) begin
        tmp        = front_m[i];
        front_m[i] = back_m[i];
        back_m[i]  = tmp;
      end
    end
    eh = (k == 0) ? 16'hFFFF : ~(16'h8000 >> r);
    check("H", H, eh);
    check("frame_start", frame_start, (k > 0) && (k % FRAME == 0));
    check("swap_done", swap_done, k == swap_at);
    check("wr_ready", wr_ready, !(swap_at >= 0 && k > req_k && k <= swap_at));
    if (chk_l) begin
      el = (p > BLANK_CYC && !dark) ? ~front_m[r] : 16'hFFFF;
      check("L", L, el);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
    check_cycle();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to(input int pos);
    for (int i = 0; i < FRAME; i++) begin
      if (k % FRAME == pos) break;
      step();
    end
  endtask

  task automatic write_row(input int r, input logic [15:0] d);
    wr_valid = 1'b1;
    wr_row   = 4'(r);
    wr_data  = d;
    step();
    wr_valid = 1'b0;
    back_m[r] = d;
  endtask

  task automatic request_swap();
    int c;
    c = k;
    if (!(swap_at >= 0 && c > req_k && c < swap_at)) begin
      req_k   = c;
      swap_at = ((c + 1) / FRAME + 1) * FRAME;
    end
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
  endtask

  task automatic wait_swap();
    for (int g = 0; g < 3 * FRAME && k < swap_at; g++) step();
  endtask

  task automatic tick_blink(input bit new_dark);
    chk_l      = 0;
    blink_tick = 1'b1;
    step();
    blink_tick = 1'b0;
    step();
    dark  = new_dark;
    chk_l = 1;
  endtask

  initial begin
    int r;
    logic [15:0] d;
    passed     = 0;
    total      = 0;
    rst        = 1'b1;
    wr_valid   = 1'b0;
    wr_row     = '0;
    wr_data    = '0;
    swap_req   = 1'b0;
    blink_en   = 1'b0;
    blink_tick = 1'b0;
`ifdef DOTMAT_PWM_EN
    brightness = 4'hF;
`endif
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst_H", H, 16'hFFFF);
    check("rst_L", L, 16'hFFFF);
    check("rst_wr_ready", wr_ready, 1'b1);
    check("rst_swap_done", swap_done, 1'b0);
    check("rst_frame_start", frame_start, 1'b0);
    rst = 1'b0;
    model_reset();
    check_cycle();
    run(FRAME + 2);

    // Random image plus the known row 3 pattern, then a swap.
    for (int i = 0; i < 6; i++) begin
      r = $urandom_range(0, ROWS - 1);
      if (r == 3) r = 4;
      write_row(r, 16'($urandom));
    end
    write_row(3, 16'hA5A5);
    run($urandom_range(0, 40));
    request_swap();
    wait_swap();
    run_to(3 * SCAN_DIV + BLANK_CYC + 3);
    check("row3_image", L, 16'h5A5A);
    run(FRAME);

    // Write held during a pending swap, plus an ignored second request.
    request_swap();
    step();
    request_swap();
    r = $urandom_range(0, ROWS - 1);
    d = 16'($urandom);
    wr_valid = 1'b1;
    wr_row   = 4'(r);
    wr_data  = d;
    for (int g = 0; g < 3 * FRAME && k < swap_at + 1; g++) step();
    step();
    wr_valid  = 1'b0;
    back_m[r] = d;
    request_swap();
    wait_swap();
    run(FRAME + 5);

    // Swap request in the exact boundary cycle is deferred a full frame.
    run_to(FRAME - 1);
    request_swap();
    wait_swap();
    run(FRAME / 2);

    // Blink: dark for a whole frame, image returns, blink_en low clears the phase.
    blink_en = 1'b1;
    tick_blink(1);
    run(FRAME + 3);
    tick_blink(0);
    run(FRAME);
    tick_blink(1);
    run(20);
    chk_l    = 0;
    blink_en = 1'b0;
    step();
    step();
    dark  = 0;
    chk_l = 1;
    run(30);
    blink_en = 1'b1;
    run(FRAME);
    blink_en = 1'b0;

    // Reset in the middle of row 9 discards everything.
    run_to(9 * SCAN_DIV + 4);
    rst = 1'b1;
    #1;
    check("midrst_H", H, 16'hFFFF);
    check("midrst_L", L, 16'hFFFF);
    check("midrst_wr_ready", wr_ready, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_cycle();
    run(FRAME + 4);
    request_swap();
    wait_swap();
    run(FRAME + 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
